// File: rtl/mux_gate_sched_if.sv
// Purpose: request/result bundle between NREQ requesters and the shared gate scheduler.
// Latency: none, wires only.
// Backpressure: req is held by a requester until its one-cycle ack pulse.
interface mux_gate_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op_in;
  logic [WIDTH*NREQ-1:0] a_in;
  logic [WIDTH*NREQ-1:0] b_in;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      y;
  logic                  y_valid;
  logic [IDW-1:0]        y_id;
  logic                  op_err;
  logic                  busy;

  // Requester side: drives requests and operands, observes completion.
  modport master (
    output req, op_in, a_in, b_in,
    input  ack, y, y_valid, y_id, op_err, busy
  );

  // Scheduler side.
  modport slave (
    input  req, op_in, a_in, b_in,
    output ack, y, y_valid, y_id, op_err, busy
  );
endinterface

// File: rtl/mux_gate_sched.sv
// Purpose: round-robin shares one mux-built bitwise gate unit between NREQ requesters.
// Latency: req seen in IDLE -> ack/y_valid 3 cycles later; one grant per 4 cycles.
// Backpressure: none on the result; requesters hold req until ack. MUX_SCHED_PRIO0_EN gives requester 0 absolute priority.
module mux_gate_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input logic             clk,
  input logic             rst,
  mux_gate_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Per-bit source selection for the gate unit: 0, 1, b, ~b.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_ONE  = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_NB   = 2'd3;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDW-1:0]   y_id_q, y_id_d;
  logic             op_err_q, op_err_d;

  logic             arb_found;
  logic [IDW-1:0]   arb_idx;

  logic [1:0]       sel_lo, sel_hi;
  logic [WIDTH-1:0] src_lo, src_hi;
  logic [WIDTH-1:0] gate_y;
  logic             gate_err;

  // Four-way source select built from two levels of 2:1 muxes.
  function automatic logic [WIDTH-1:0] mux_src(input logic [1:0] sel, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] lvl_const, lvl_b;
    lvl_const = sel[0] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    lvl_b     = sel[0] ? ~b : b;
    return sel[1] ? lvl_b : lvl_const;
  endfunction

  // Arbitration: first asserted req at or after rr_ptr, then wrap to the low indices.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
`ifdef MUX_SCHED_PRIO0_EN
    if (bus.req[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
    for (int i = 1; i < NREQ; i++) begin
      if (!arb_found && bus.req[i] && i >= int'(rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(i);
      end
    end
    for (int i = 1; i < NREQ; i++) begin
      if (!arb_found && bus.req[i] && i < int'(rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(i);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && bus.req[i] && i >= int'(rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && bus.req[i] && i < int'(rr_ptr_q)) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(i);
      end
    end
`endif
  end

  // Gate unit: each output bit is a 2:1 mux on a between two functions of b.
  always_comb begin
    sel_lo   = SRC_ZERO;
    sel_hi   = SRC_ZERO;
    gate_err = 1'b0;
    case (op_q)
      3'd0: begin sel_lo = SRC_ZERO; sel_hi = SRC_B;    end // AND
      3'd1: begin sel_lo = SRC_B;    sel_hi = SRC_ONE;  end // OR
      3'd2: begin sel_lo = SRC_ONE;  sel_hi = SRC_ZERO; end // NOT a
      3'd3: begin sel_lo = SRC_B;    sel_hi = SRC_NB;   end // XOR
      3'd4: begin sel_lo = SRC_NB;   sel_hi = SRC_B;    end // XNOR
      3'd5: begin sel_lo = SRC_ONE;  sel_hi = SRC_NB;   end // NAND
      3'd6: begin sel_lo = SRC_NB;   sel_hi = SRC_ZERO; end // NOR
      default: gate_err = 1'b1;                             // invalid -> y=0
    endcase
    src_lo = mux_src(sel_lo, b_q);
    src_hi = mux_src(sel_hi, b_q);
    for (int k = 0; k < WIDTH; k++) begin
      gate_y[k] = a_q[k] ? src_hi[k] : src_lo[k];
    end
  end

  // Sequencer next state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    y_id_d   = y_id_q;
    op_err_d = op_err_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) state_d = S_ARB;
      end
      S_ARB: begin
        // Operands are captured only here; later operand changes are ignored.
        if (arb_found) begin
          win_d   = arb_idx;
          state_d = S_EXEC;
          for (int i = 0; i < NREQ; i++) begin
            if (int'(arb_idx) == i) begin
              op_d = bus.op_in[3*i +: 3];
              a_d  = bus.a_in[WIDTH*i +: WIDTH];
              b_d  = bus.b_in[WIDTH*i +: WIDTH];
            end
          end
        end else begin
          // Request vanished between IDLE and ARB: nothing to serve.
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        y_d      = gate_y;
        op_err_d = gate_err;
        y_id_d   = win_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
`ifdef MUX_SCHED_PRIO0_EN
        // Requester 0 wins outside the rotation, so it never moves the pointer.
        if (win_q != '0) begin
          rr_ptr_d = (int'(win_q) == NREQ-1) ? '0 : win_q + IDW'(1);
        end
`else
        rr_ptr_d = (int'(win_q) == NREQ-1) ? '0 : win_q + IDW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      y_id_q   <= '0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      y_id_q   <= y_id_d;
      op_err_q <= op_err_d;
    end
  end

  // Outputs: ack and y_valid pulse for the single RESP cycle.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.ack[i] = (state_q == S_RESP) && (int'(win_q) == i);
    end
    bus.y_valid = (state_q == S_RESP);
    bus.busy    = (state_q != S_IDLE);
    bus.y       = y_q;
    bus.y_id    = y_id_q;
    bus.op_err  = op_err_q;
  end

endmodule

// File: tb/tb_mux_gate_sched.sv
// Purpose: scenario bench for mux_gate_sched; expectations queued on drive, compared on y_valid.
// Latency: checks the 3-cycle grant latency and 4-cycle grant spacing.
// Backpressure: requesters hold req until ack; MUX_SCHED_PRIO0_EN selects the priority-0 expectations.
module tb_mux_gate_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] y;
    logic [IDW-1:0]   id;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mux_gate_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  mux_gate_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference gate written with plain operators.
  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return a ^ b;
      3'd4: return ~(a ^ b);
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic set_slot(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.op_in[3*i +: 3]         = op;
    bus.a_in[WIDTH*i +: WIDTH]  = a;
    bus.b_in[WIDTH*i +: WIDTH]  = b;
  endtask

  // Waits on falling edges for y_valid; returns how many edges it took.
  task automatic wait_resp(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (bus.y_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst  = 1'b0;
  endtask

  task automatic test_reset();
    bus.op_in = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks += 4;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c=%0d got %b want 0", c, bus.busy); end
      if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack c=%0d got %b want 0000", c, bus.ack); end
      if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL reset_y c=%0d got %b want 0000", c, bus.y); end
      if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid c=%0d got %b want 0", c, bus.y_valid); end
    end
  endtask

  task automatic test_ops();
    logic [WIDTH-1:0] exp_y [7];
    exp_t e;
    int   cyc;
    bit   seen;
    exp_y = '{4'b1000, 4'b1110, 4'b0011, 4'b0110, 4'b1001, 4'b0111, 4'b0001};
    for (int op = 0; op < 7; op++) begin
      @(posedge clk);
      #1;
      set_slot(0, 3'(op), 4'b1100, 4'b1010);
      bus.req = 4'b0001;
      sb_q.push_back('{ack: 4'b0001, y: exp_y[op], id: 2'd0, err: 1'b0});
      if (op == 0) begin
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ops_busy_arb got %b want 1", bus.busy); end
        wait_resp(20, cyc, seen);
        cyc += 2;
      end else begin
        wait_resp(20, cyc, seen);
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL ops_timeout op=%0d got no y_valid want y_valid", op);
        bus.req = '0;
        continue;
      end
      e = sb_q.pop_front();
      bus.req = '0;
      n_checks += 5;
      if (cyc !== 4) begin n_fail++; $display("FAIL ops_latency op=%0d got %0d want 4", op, cyc); end
      if (bus.ack !== e.ack) begin n_fail++; $display("FAIL ops_ack op=%0d got %b want %b", op, bus.ack, e.ack); end
      if (bus.y !== e.y) begin n_fail++; $display("FAIL ops_y op=%0d got %b want %b", op, bus.y, e.y); end
      if (bus.y_id !== e.id) begin n_fail++; $display("FAIL ops_y_id op=%0d got %0d want %0d", op, bus.y_id, e.id); end
      if (bus.op_err !== e.err) begin n_fail++; $display("FAIL ops_op_err op=%0d got %b want %b", op, bus.op_err, e.err); end
      @(negedge clk);
      n_checks += 3;
      if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL ops_pulse_valid op=%0d got %b want 0", op, bus.y_valid); end
      if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL ops_pulse_ack op=%0d got %b want 0000", op, bus.ack); end
      if (bus.y !== e.y) begin n_fail++; $display("FAIL ops_y_hold op=%0d got %b want %b", op, bus.y, e.y); end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] av [NREQ];
    logic [WIDTH-1:0] bv [NREQ];
    int   order [5];
    exp_t e;
    int   cyc;
    bit   seen;
    av = '{4'b1100, 4'b0101, 4'b1111, 4'b0010};
    bv = '{4'b1010, 4'b0011, 4'b0110, 4'b1011};
`ifdef MUX_SCHED_PRIO0_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_slot(i, 3'd3, av[i], bv[i]);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      sb_q.push_back('{ack: 4'(1 << order[k]), y: ref_gate(3'd3, av[order[k]], bv[order[k]]),
                       id: 2'(order[k]), err: 1'b0});
    end
    for (int k = 0; k < 5; k++) begin
      wait_resp(20, cyc, seen);
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL b2b_timeout k=%0d got no y_valid want y_valid", k);
        break;
      end
      e = sb_q.pop_front();
      n_checks += 4;
      if (cyc !== 4) begin n_fail++; $display("FAIL b2b_spacing k=%0d got %0d want 4", k, cyc); end
      if (bus.ack !== e.ack) begin n_fail++; $display("FAIL b2b_ack k=%0d got %b want %b", k, bus.ack, e.ack); end
      if (bus.y !== e.y) begin n_fail++; $display("FAIL b2b_y k=%0d got %b want %b", k, bus.y, e.y); end
      if (bus.y_id !== e.id) begin n_fail++; $display("FAIL b2b_y_id k=%0d got %0d want %0d", k, bus.y_id, e.id); end
    end
    sb_q.delete();
    bus.req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_invalid_op();
    exp_t e;
    int   cyc;
    bit   seen;
    @(posedge clk);
    #1;
    set_slot(2, 3'd7, 4'b1111, 4'b0101);
    bus.req = 4'b0100;
    sb_q.push_back('{ack: 4'b0100, y: 4'b0000, id: 2'd2, err: 1'b1});
    wait_resp(20, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL inv_timeout got no y_valid want y_valid");
      bus.req = '0;
      return;
    end
    e = sb_q.pop_front();
    bus.req = '0;
    n_checks += 4;
    if (bus.y !== e.y) begin n_fail++; $display("FAIL inv_y got %b want %b", bus.y, e.y); end
    if (bus.op_err !== e.err) begin n_fail++; $display("FAIL inv_op_err got %b want %b", bus.op_err, e.err); end
    if (bus.y_id !== e.id) begin n_fail++; $display("FAIL inv_y_id got %0d want %0d", bus.y_id, e.id); end
    if (bus.ack !== e.ack) begin n_fail++; $display("FAIL inv_ack got %b want %b", bus.ack, e.ack); end
    @(negedge clk);
    n_checks++;
    if (bus.op_err !== 1'b1) begin n_fail++; $display("FAIL inv_op_err_hold got %b want 1", bus.op_err); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   cyc;
    bit   seen;
    do_reset();
    // Serve requester 1 so the pointer moves to 2 and y holds a nonzero result.
    @(posedge clk);
    #1;
    set_slot(1, 3'd1, 4'b1010, 4'b0101);
    bus.req = 4'b0010;
    sb_q.push_back('{ack: 4'b0010, y: 4'b1111, id: 2'd1, err: 1'b0});
    wait_resp(20, cyc, seen);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL mrst_pre_timeout got no y_valid want y_valid"); end
    e = sb_q.pop_front();
    bus.req = '0;
    n_checks++;
    if (bus.y !== e.y) begin n_fail++; $display("FAIL mrst_pre_y got %b want %b", bus.y, e.y); end
    @(negedge clk);
    // Abort requester 1 while its grant is executing.
    @(posedge clk);
    #1;
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 6;
    if (bus.y !== 4'b0000) begin n_fail++; $display("FAIL mrst_y got %b want 0000", bus.y); end
    if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_y_valid got %b want 0", bus.y_valid); end
    if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL mrst_ack got %b want 0000", bus.ack); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got %b want 0", bus.busy); end
    if (bus.y_id !== 2'd0) begin n_fail++; $display("FAIL mrst_y_id got %0d want 0", bus.y_id); end
    if (bus.op_err !== 1'b0) begin n_fail++; $display("FAIL mrst_op_err got %b want 0", bus.op_err); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.y_valid !== 1'b0 || bus.ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL mrst_no_ack c=%0d got ack=%b y_valid=%b want 0000/0", c, bus.ack, bus.y_valid);
      end
    end
    // Pointer restarts at 0: requester 0 wins first with all pending.
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_slot(i, 3'd0, 4'b1111, 4'(i + 1));
    bus.req = 4'b1111;
    sb_q.push_back('{ack: 4'b0001, y: ref_gate(3'd0, 4'b1111, 4'd1), id: 2'd0, err: 1'b0});
    wait_resp(20, cyc, seen);
    bus.req = '0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mrst_post_timeout got no y_valid want y_valid");
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    n_checks += 2;
    if (bus.ack !== e.ack) begin n_fail++; $display("FAIL mrst_post_ack got %b want %b", bus.ack, e.ack); end
    if (bus.y !== e.y) begin n_fail++; $display("FAIL mrst_post_y got %b want %b", bus.y, e.y); end
    @(negedge clk);
  endtask

  task automatic test_operand_latch();
    exp_t e;
    int   cyc;
    bit   seen;
    @(posedge clk);
    #1;
    set_slot(0, 3'd0, 4'b1100, 4'b1010);
    bus.req = 4'b0001;
    sb_q.push_back('{ack: 4'b0001, y: 4'b1000, id: 2'd0, err: 1'b0});
    repeat (3) @(negedge clk);
    // Now in EXEC: change operands and drop req early; grant must still finish.
    set_slot(0, 3'd1, 4'b0011, 4'b0000);
    bus.req = '0;
    wait_resp(20, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL latch_timeout got no y_valid want y_valid");
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    n_checks += 3;
    if (bus.y !== e.y) begin n_fail++; $display("FAIL latch_y got %b want %b", bus.y, e.y); end
    if (bus.ack !== e.ack) begin n_fail++; $display("FAIL latch_ack got %b want %b", bus.ack, e.ack); end
    if (cyc !== 1) begin n_fail++; $display("FAIL latch_latency got %0d want 1", cyc); end
  endtask

  initial begin
    bus.req   = '0;
    bus.op_in = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_invalid_op();
    test_mid_reset();
    test_operand_latch();
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
